// File: rtl/ripple_sub_pkg.sv
// ripple_sub_pkg
//   Shared constants and a reference helper for the pipelined ripple-borrow
//   subtractor.
//   - RIPPLE_SUB_WIDTH / RIPPLE_SUB_SPLIT : default operand width and the
//     number of low bits resolved in the first pipeline stage.
//   - ripple_sub_ref() : returns {borrow_out, difference} for ina - inb - b_in,
//     computed arithmetically (not through bit cells), default width only.
package ripple_sub_pkg;

  localparam int RIPPLE_SUB_WIDTH = 8;
  localparam int RIPPLE_SUB_SPLIT = 4;

  // Zero-extending to WIDTH+1 bits makes the top bit of the result the borrow:
  // any negative true difference wraps to a value with bit WIDTH set.
  function automatic logic [RIPPLE_SUB_WIDTH:0] ripple_sub_ref(
    input logic [RIPPLE_SUB_WIDTH-1:0] a,
    input logic [RIPPLE_SUB_WIDTH-1:0] b,
    input logic                        bin
  );
    logic [RIPPLE_SUB_WIDTH:0] r;
    r = {1'b0, a} - {1'b0, b} - {{RIPPLE_SUB_WIDTH{1'b0}}, bin};
    return r;
  endfunction

endpackage

// File: rtl/ripple_subtractor_full_sub.sv
// full_sub
//   One-bit full subtractor cell: d = a - b - bin, with borrow out.
//   Ports:
//     a    : minuend bit
//     b    : subtrahend bit
//     bin  : borrow from the next lower bit
//     d    : difference bit
//     bout : borrow into the next higher bit
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a, or when a == b and a borrow is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/ripple_subtractor.sv
// ripple_subtractor
//   Two-stage pipelined ripple-borrow subtractor: DIFF = ina - inb - b_in.
//   Stage 1 resolves the low SPLIT bits and registers the intermediate borrow
//   together with the untouched upper operand bits; stage 2 resolves the upper
//   WIDTH-SPLIT bits and registers DIFF / b_out / out_valid.
//
//   Optional feature: define RIPPLE_SUB_OVF_EN to add the registered signed
//   overflow output ovf. Without it the port and its logic are absent.
//
//   Ports:
//     clk, rst          : rising-edge clock, asynchronous active-high reset
//     in_valid/in_ready : operand stream handshake
//     ina, inb, b_in    : minuend, subtrahend, borrow in
//     out_valid/out_ready : result stream handshake
//     DIFF, b_out       : registered difference and borrow out
//     ovf               : signed overflow (RIPPLE_SUB_OVF_EN only)
//
//   Handshake: a beat transfers on a rising edge where valid && ready. A
//   producer holds valid and its data stable until the transfer; ready may
//   depend combinationally on the downstream ready (out_ready -> in_ready),
//   valid never depends on ready. Outputs stay stable while
//   out_valid && !out_ready.
module ripple_subtractor
  import ripple_sub_pkg::*;
#(
  parameter int WIDTH = RIPPLE_SUB_WIDTH,
  parameter int SPLIT = RIPPLE_SUB_SPLIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] DIFF,
  output logic             b_out
`ifdef RIPPLE_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int HI_W = WIDTH - SPLIT;

  // ---------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic out_valid_q, out_valid_d;
  logic s2_adv, s1_adv, accept;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign accept   = in_valid && s1_adv;
  assign in_ready = s1_adv;

  // ---------------------------------------------------------------------
  // Stage 1: low SPLIT bits through the bit-cell chain
  // ---------------------------------------------------------------------
  logic [SPLIT:0]   lo_b;
  logic [SPLIT-1:0] lo_d;

  assign lo_b[0] = b_in;

  for (genvar gi = 0; gi < SPLIT; gi++) begin : g_lo
    full_sub u_cell (
      .a    (ina[gi]),
      .b    (inb[gi]),
      .bin  (lo_b[gi]),
      .d    (lo_d[gi]),
      .bout (lo_b[gi+1])
    );
  end

  logic [SPLIT-1:0] s1_lo_q, s1_lo_d;
  logic             s1_borrow_q, s1_borrow_d;
  // The upper operand bits include both MSBs, which the overflow term needs.
  logic [HI_W-1:0]  s1_ina_hi_q, s1_ina_hi_d;
  logic [HI_W-1:0]  s1_inb_hi_q, s1_inb_hi_d;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_lo_d     = s1_lo_q;
    s1_borrow_d = s1_borrow_q;
    s1_ina_hi_d = s1_ina_hi_q;
    s1_inb_hi_d = s1_inb_hi_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
    end
    // Data only loads on a real transfer; an empty advance leaves it stale.
    if (accept) begin
      s1_lo_d     = lo_d;
      s1_borrow_d = lo_b[SPLIT];
      s1_ina_hi_d = ina[WIDTH-1:SPLIT];
      s1_inb_hi_d = inb[WIDTH-1:SPLIT];
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: upper bits, continuing from the registered stage-1 borrow
  // ---------------------------------------------------------------------
  logic [HI_W:0]   hi_b;
  logic [HI_W-1:0] hi_d;

  assign hi_b[0] = s1_borrow_q;

  for (genvar gj = 0; gj < HI_W; gj++) begin : g_hi
    full_sub u_cell (
      .a    (s1_ina_hi_q[gj]),
      .b    (s1_inb_hi_q[gj]),
      .bin  (hi_b[gj]),
      .d    (hi_d[gj]),
      .bout (hi_b[gj+1])
    );
  end

  logic [WIDTH-1:0] diff_q, diff_d;
  logic             b_out_q, b_out_d;

  always_comb begin
    out_valid_d = out_valid_q;
    diff_d      = diff_q;
    b_out_d     = b_out_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
    end
    if (s2_adv && s1_valid_q) begin
      diff_d  = {hi_d, s1_lo_q};
      b_out_d = hi_b[HI_W];
    end
  end

`ifdef RIPPLE_SUB_OVF_EN
  logic ovf_q, ovf_d;

  // Two's-complement overflow: operand signs differ and the result sign
  // disagrees with the minuend sign.
  always_comb begin
    ovf_d = ovf_q;
    if (s2_adv && s1_valid_q) begin
      ovf_d = (s1_ina_hi_q[HI_W-1] != s1_inb_hi_q[HI_W-1]) &&
              (hi_d[HI_W-1] != s1_ina_hi_q[HI_W-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_lo_q     <= '0;
      s1_borrow_q <= 1'b0;
      s1_ina_hi_q <= '0;
      s1_inb_hi_q <= '0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      b_out_q     <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_lo_q     <= s1_lo_d;
      s1_borrow_q <= s1_borrow_d;
      s1_ina_hi_q <= s1_ina_hi_d;
      s1_inb_hi_q <= s1_inb_hi_d;
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      b_out_q     <= b_out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign DIFF      = diff_q;
  assign b_out     = b_out_q;

endmodule

// File: tb/tb_ripple_subtractor.sv
// tb_ripple_subtractor
//   Directed bench for ripple_subtractor (default WIDTH=8, SPLIT=4).
//   Define RIPPLE_SUB_OVF_EN for both DUT and bench to include ovf checks.
module tb_ripple_subtractor;
  import ripple_sub_pkg::*;

  localparam int W = RIPPLE_SUB_WIDTH;

  // ---------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------
  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] ina;
  logic [W-1:0] inb;
  logic         b_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] DIFF;
  logic         b_out;
`ifdef RIPPLE_SUB_OVF_EN
  logic         ovf;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ripple_subtractor #(.WIDTH(W), .SPLIT(RIPPLE_SUB_SPLIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ina       (ina),
    .inb       (inb),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .DIFF      (DIFF),
    .b_out     (b_out)
`ifdef RIPPLE_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // ---------------------------------------------------------------------
  // Counters and check helper
  // ---------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  int accept_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Scoreboard: {ovf, b_out, DIFF} per accepted beat, checked in order
  // ---------------------------------------------------------------------
  logic [W+1:0] exp_q[$];

  function automatic logic [W+1:0] expect_of(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic bin);
    logic [W:0] r;
    logic       o;
    r = ripple_sub_ref(a, b, bin);
    o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    return {o, r};
  endfunction

  // Sampled 2 time units after the falling edge, when the driver has settled
  // and nothing changes until the next rising edge.
  always @(negedge clk) begin
    logic [W+1:0] e;
    #2;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got DIFF=0x%0h b_out=%0b expected no output", DIFF, b_out);
        end else begin
          e = exp_q.pop_front();
          check("sb_diff", 32'(DIFF), 32'(e[W-1:0]));
          check("sb_bout", 32'(b_out), 32'(e[W]));
`ifdef RIPPLE_SUB_OVF_EN
          check("sb_ovf", 32'(ovf), 32'(e[W+1]));
`endif
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(expect_of(ina, inb, b_in));
        accept_cnt++;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs[NVEC];

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    ina      = a;
    inb      = b;
    b_in     = bin;
    in_valid = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------
  initial begin
    vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h10, 8'h01, 1'b1, 8'h0E, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'h0F, 8'h0F, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1};
    vecs[7] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[8] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[9] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    ina       = '0;
    inb       = '0;
    b_in      = 1'b0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(DIFF), 32'd0);
    check("rst_bout", 32'(b_out), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // Table: one beat at a time, latency and values checked explicitly
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      drive(vecs[i].a, vecs[i].b, vecs[i].bin);
      #1;
      check("vec_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check("vec_lat1_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("vec_lat2_valid", 32'(out_valid), 32'd1);
      check("vec_diff", 32'(DIFF), 32'(vecs[i].diff));
      check("vec_bout", 32'(b_out), 32'(vecs[i].bout));
`ifdef RIPPLE_SUB_OVF_EN
      check("vec_ovf", 32'(ovf), 32'(vecs[i].ovf));
`endif
    end

    // Streaming: three back-to-back beats, three consecutive results
    @(negedge clk);
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: drive(8'h35, 8'h12, 1'b0);
        1: drive(8'h00, 8'h01, 1'b0);
        2: drive(8'h10, 8'h01, 1'b1);
        default: in_valid = 1'b0;
      endcase
      if (c >= 2 && c <= 4) check("stream_valid", 32'(out_valid), 32'd1);
      if (c == 5) check("stream_idle", 32'(out_valid), 32'd0);
      @(negedge clk);
    end

    // Stall: consumer blocked, producer keeps offering beats
    begin
      int acc0;
      acc0 = accept_cnt;
      out_ready = 1'b0;
      drive(8'hC3, 8'h3C, 1'b0);
      @(negedge clk);
      drive(8'h01, 8'h02, 1'b1);
      @(negedge clk);
      drive(8'h99, 8'h11, 1'b0);
      for (int k = 0; k < 4; k++) begin
        #1;
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_diff", 32'(DIFF), 32'h87);
        check("stall_bout", 32'(b_out), 32'd0);
        if (k < 3) @(negedge clk);
      end
      check("stall_accepts", 32'(accept_cnt - acc0), 32'd2);
      // Release: the held beat is accepted in the same cycle the head drains
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(negedge clk);
      check("stall_drain_empty", 32'(exp_q.size()), 32'd0);
      check("stall_total_accepts", 32'(accept_cnt - acc0), 32'd3);
    end

    // Asynchronous reset with both stages occupied
    @(negedge clk);
    out_ready = 1'b0;
    drive(8'h44, 8'h11, 1'b0);
    @(negedge clk);
    drive(8'h20, 8'h30, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre_rst_in_ready", 32'(in_ready), 32'd0);
    check("pre_rst_diff", 32'(DIFF), 32'h33);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_diff", 32'(DIFF), 32'd0);
    check("arst_bout", 32'(b_out), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
`ifdef RIPPLE_SUB_OVF_EN
    check("arst_ovf", 32'(ovf), 32'd0);
`endif
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_no_output", 32'(out_valid), 32'd0);
    end

    // One beat after reset to show operation resumes
    drive(8'h40, 8'h04, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("resume_valid", 32'(out_valid), 32'd1);
    check("resume_diff", 32'(DIFF), 32'h3B);
    repeat (2) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
